// File: rtl/mcs48_sys_if.sv
// mcs48_sys_if
// System interface for an MCS-48 class sound CPU core.
//   - internal data RAM (2^DMEM_AW bytes, registered write-first read)
//   - ALE/PSENn demux of the multiplexed bus into external program ROM fetches
//   - NUM_CMD-channel command mailbox from the main CPU, with active-low interrupt
//   - MOVX-write latch feeding the audio DAC
//
// Ports
//   I_CLK, I_RST                 clock, synchronous active-high reset
//   I_ALE, I_PSENn, I_RDn, I_WRn core bus strobes (sampled, edge-detected)
//   I_DB_CPU / O_DB_CPU          core data bus out / registered data back to core
//   I_P2                         core port 2, [3:0] = high program address
//   O_ROM_A, O_ROM_RD, I_ROM_D   program ROM address, one-cycle read request, data
//   I_DMEM_A/WE/D, O_DMEM_D      core internal data RAM port
//   I_CMD_WE/SEL/D               main CPU mailbox write
//   O_CMD_PEND, O_INTn           per-channel pending flags, interrupt to core
//   O_DAC, O_DAC_STB             DAC latch and its one-cycle update strobe
module mcs48_sys_if #(
    parameter int DMEM_AW = 6,
    parameter int PMEM_AW = 12,
    parameter int NUM_CMD = 2,
    parameter int ROM_LAT = 1,
    localparam int CSW = (NUM_CMD > 1) ? $clog2(NUM_CMD) : 1
) (
    input  logic               I_CLK,
    input  logic               I_RST,
    input  logic               I_ALE,
    input  logic               I_PSENn,
    input  logic               I_RDn,
    input  logic               I_WRn,
    input  logic [7:0]         I_DB_CPU,
    output logic [7:0]         O_DB_CPU,
    input  logic [7:0]         I_P2,
    output logic [PMEM_AW-1:0] O_ROM_A,
    output logic               O_ROM_RD,
    input  logic [7:0]         I_ROM_D,
    input  logic [7:0]         I_DMEM_A,
    input  logic               I_DMEM_WE,
    input  logic [7:0]         I_DMEM_D,
    output logic [7:0]         O_DMEM_D,
    input  logic               I_CMD_WE,
    input  logic [CSW-1:0]     I_CMD_SEL,
    input  logic [7:0]         I_CMD_D,
    output logic [NUM_CMD-1:0] O_CMD_PEND,
    output logic               O_INTn,
    output logic [7:0]         O_DAC,
    output logic               O_DAC_STB
);

    logic                     ale_q, psen_q, rdn_q, wrn_q;
    logic                     edge_mask_q;
    logic [7:0]               addr_lo_q;
    logic [1:0]               lat_cnt_q;
    logic [7:0]               rom_q;
    logic [7:0]               rd_q, rd_d;
    logic [7:0]               wr_smp_q;
    logic [NUM_CMD-1:0]       pend_q, pend_d;
    logic [NUM_CMD-1:0][7:0]  cmd_q, cmd_d;
    logic [PMEM_AW-1:0]       rom_a_q;
    logic                     rom_rd_q;
    logic [7:0]               db_q;
    logic                     intn_q;
    logic [7:0]               dac_q;
    logic                     dac_stb_q;
    logic [7:0]               dmem_q;
    logic [7:0]               mem [2**DMEM_AW];

    logic                     ale_fall, psen_fall, rd_fall, wr_rise;
    logic [11:0]              fetch_a;
    logic [6:0]               rd_idx;
    logic                     unused_bits;

    // edge_mask_q blanks strobe falling edges for the first cycle after reset,
    // so a strobe held low through reset does not start a fetch or a read.
    assign ale_fall  = ale_q & ~I_ALE;
    assign psen_fall = psen_q & ~I_PSENn & ~edge_mask_q;
    assign rd_fall   = rdn_q & ~I_RDn & ~edge_mask_q;
    assign wr_rise   = ~wrn_q & I_WRn;
    assign fetch_a   = {I_P2[3:0], addr_lo_q};
    // Whole low 7 bits must name a channel; unmapped mailbox addresses read FF.
    assign rd_idx    = addr_lo_q[6:0];
    assign unused_bits = ^{I_P2[7:4], I_DMEM_A, fetch_a};

    // Mailbox: a same-cycle command write beats the read-clear of its channel,
    // while the read still returns the byte held before that write.
    always_comb begin
        pend_d = pend_q;
        cmd_d  = cmd_q;
        rd_d   = rd_q;
        if (rd_fall) begin
            if (addr_lo_q[7]) begin
                rd_d = 8'h00;
                rd_d[NUM_CMD-1:0] = pend_q;
            end else begin
                rd_d = 8'hFF;
                for (int c = 0; c < NUM_CMD; c++) begin
                    if (rd_idx == 7'(c)) begin
                        rd_d      = cmd_q[c];
                        pend_d[c] = 1'b0;
                    end
                end
            end
        end
        if (I_CMD_WE) begin
            for (int c = 0; c < NUM_CMD; c++) begin
                if (I_CMD_SEL == CSW'(c)) begin
                    cmd_d[c]  = I_CMD_D;
                    pend_d[c] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        if (!I_RST && I_DMEM_WE) begin
            mem[I_DMEM_A[DMEM_AW-1:0]] <= I_DMEM_D;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            ale_q       <= 1'b0;
            psen_q      <= 1'b1;
            rdn_q       <= 1'b1;
            wrn_q       <= 1'b1;
            edge_mask_q <= 1'b1;
            addr_lo_q   <= 8'h00;
            lat_cnt_q   <= 2'd0;
            rom_q       <= 8'h00;
            rd_q        <= 8'hFF;
            wr_smp_q    <= 8'h00;
            pend_q      <= '0;
            cmd_q       <= '0;
            rom_a_q     <= '0;
            rom_rd_q    <= 1'b0;
            db_q        <= 8'hFF;
            intn_q      <= 1'b1;
            dac_q       <= 8'h00;
            dac_stb_q   <= 1'b0;
            dmem_q      <= 8'h00;
        end else begin
            ale_q       <= I_ALE;
            psen_q      <= I_PSENn;
            rdn_q       <= I_RDn;
            wrn_q       <= I_WRn;
            edge_mask_q <= 1'b0;

            if (ale_fall) begin
                addr_lo_q <= I_DB_CPU;
            end

            // Latency down-counter: loaded at the request, ROM data is taken
            // when it reaches 1, i.e. ROM_LAT cycles after the O_ROM_RD cycle.
            rom_rd_q <= psen_fall;
            if (psen_fall) begin
                rom_a_q   <= fetch_a[PMEM_AW-1:0];
                lat_cnt_q <= 2'(ROM_LAT + 1);
            end else if (lat_cnt_q != 2'd0) begin
                lat_cnt_q <= lat_cnt_q - 2'd1;
            end
            if (lat_cnt_q == 2'd1) begin
                rom_q <= I_ROM_D;
            end

            rd_q   <= rd_d;
            pend_q <= pend_d;
            cmd_q  <= cmd_d;
            intn_q <= ~(|pend_q);

            if (!I_WRn) begin
                wr_smp_q <= I_DB_CPU;
            end
            dac_stb_q <= wr_rise;
            if (wr_rise) begin
                dac_q <= wr_smp_q;
            end

            if (!I_PSENn) begin
                db_q <= rom_q;
            end else if (!I_RDn) begin
                db_q <= rd_q;
            end else begin
                db_q <= 8'hFF;
            end

            dmem_q <= I_DMEM_WE ? I_DMEM_D : mem[I_DMEM_A[DMEM_AW-1:0]];
        end
    end

    assign O_DB_CPU   = db_q;
    assign O_ROM_A    = rom_a_q;
    assign O_ROM_RD   = rom_rd_q;
    assign O_DMEM_D   = dmem_q;
    assign O_CMD_PEND = pend_q;
    assign O_INTn     = intn_q;
    assign O_DAC      = dac_q;
    assign O_DAC_STB  = dac_stb_q;

endmodule
